// File: rtl/pulpino_spi_master_subsystem_global_pkg.sv
// Shared types and limits for the SPI slave frame responder.
package pulpino_spi_master_subsystem_global_pkg;

  localparam int SPI_SLV_MAX_CMD_LEN  = 32;
  localparam int SPI_SLV_MAX_ADDR_LEN = 32;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, DATA, DONE, IGNORE
  } spi_slv_state_e;

  // Phase that follows a completed pre-DATA phase; empty phases are skipped.
  function automatic spi_slv_state_e spi_slv_next_phase(spi_slv_state_e cur, logic addr_nz,
                                                        logic dummy_nz, logic data_nz);
    spi_slv_state_e nxt;
    nxt = DONE;
    if (cur == CMD && addr_nz)                          nxt = ADDR;
    else if ((cur == CMD || cur == ADDR) && dummy_nz)   nxt = DUMMY;
    else if (data_nz)                                   nxt = DATA;
    return nxt;
  endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Two-flop synchronizer plus one edge register for a single async SPI pin.
module spi_slave_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  // Shift the pin through the synchronizer; keep the previous synced level for edge detect
  always_comb begin
    sync_d = {sync_q[0], d_i};
    prev_d = sync_q[1];
  end

  // Synchronizer and edge registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {2{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign lvl_o  = sync_q[1];
  assign rise_o = sync_q[1] & ~prev_q;
  assign fall_o = ~sync_q[1] & prev_q;

endmodule

// File: rtl/spi_slave_frame_responder.sv
// SPI mode-0 slave: splits each CS frame into CMD/ADDR/DUMMY/DATA, reports
// write frames and serves read frames on MISO.
module spi_slave_frame_responder
  import pulpino_spi_master_subsystem_global_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [5:0]        cmd_len,
  input  logic [5:0]        addr_len,
  input  logic [15:0]       dummy_len,
  input  logic [15:0]       data_len,
  input  logic [31:0]       rd_cmd,
  output logic              rd_req,
  input  logic [DATA_W-1:0] rd_data,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [31:0]       cmd,
  output logic [31:0]       addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              is_read
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_slave_sync_edge #(.RST_VAL(1'b0)) u_sclk (.clk(clk), .rstn(rstn), .d_i(spi_sclk),
    .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_slave_sync_edge #(.RST_VAL(1'b1)) u_cs (.clk(clk), .rstn(rstn), .d_i(spi_cs_n),
    .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
  spi_slave_sync_edge #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .rstn(rstn), .d_i(spi_mosi),
    .lvl_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

  assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

  spi_slv_state_e    state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [5:0]        cmd_len_q, cmd_len_d, addr_len_q, addr_len_d;
  logic [15:0]       dummy_len_q, dummy_len_d, data_len_q, data_len_d;
  logic [31:0]       rd_cmd_q, rd_cmd_d;
  logic [31:0]       cmd_q, cmd_d, addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, sh_q, sh_d;
  logic              is_read_q, is_read_d;
  logic              rd_req_q, rd_req_d, frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;

  logic              phase_done, illegal;
  logic [15:0]       cnt_inc, shamt;
  logic [31:0]       cmd_sh, addr_sh;
  logic [DATA_W-1:0] wr_sh;

  // Frame sequencing, field capture and MISO shifter control
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_len_d     = cmd_len_q;
    addr_len_d    = addr_len_q;
    dummy_len_d   = dummy_len_q;
    data_len_d    = data_len_q;
    rd_cmd_d      = rd_cmd_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    wr_data_d     = wr_data_q;
    sh_d          = sh_q;
    is_read_d     = is_read_q;
    rd_req_d      = 1'b0;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    phase_done    = 1'b0;
    cnt_inc       = cnt_q + 16'd1;
    cmd_sh        = {cmd_q[30:0], mosi_lvl};
    addr_sh       = {addr_q[30:0], mosi_lvl};
    wr_sh         = {wr_data_q[DATA_W-2:0], mosi_lvl};
    // Left-align the requested bits so MISO always drives the shifter MSB
    shamt         = 16'(DATA_W) - data_len_q;
    illegal       = (cmd_len == 6'd0) || (int'(cmd_len) > SPI_SLV_MAX_CMD_LEN) ||
                    (int'(addr_len) > SPI_SLV_MAX_ADDR_LEN) || (int'(data_len) > DATA_W);

    // Read data arrives exactly one clk after the request pulse
    if (rd_req_q) sh_d = rd_data << shamt;

    if (cs_rise) begin
      // CS rise beats any same-cycle SCLK edge
      if (state_q inside {CMD, ADDR, DUMMY, DATA}) frame_err_d = 1'b1;
      if (state_q == DONE) frame_valid_d = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (cs_fall) begin
          cmd_len_d   = cmd_len;
          addr_len_d  = addr_len;
          dummy_len_d = dummy_len;
          data_len_d  = data_len;
          rd_cmd_d    = rd_cmd;
          cmd_d       = '0;
          addr_d      = '0;
          wr_data_d   = '0;
          sh_d        = '0;
          is_read_d   = 1'b0;
          cnt_d       = '0;
          if (illegal) begin
            frame_err_d = 1'b1;
            state_d     = IGNORE;
          end else begin
            state_d = CMD;
          end
        end
        CMD: if (sclk_rise) begin
          cmd_d = cmd_sh;
          cnt_d = cnt_inc;
          if (cnt_inc == 16'(cmd_len_q)) begin
            is_read_d  = (cmd_sh == rd_cmd_q);
            phase_done = 1'b1;
          end
        end
        ADDR: if (sclk_rise) begin
          addr_d = addr_sh;
          cnt_d  = cnt_inc;
          if (cnt_inc == 16'(addr_len_q)) phase_done = 1'b1;
        end
        DUMMY: if (sclk_rise) begin
          cnt_d = cnt_inc;
          if (cnt_inc == dummy_len_q) phase_done = 1'b1;
        end
        DATA: begin
          if (sclk_rise) begin
            if (!is_read_q) wr_data_d = wr_sh;
            cnt_d = cnt_inc;
            if (cnt_inc == data_len_q) state_d = DONE;
          end else if (sclk_fall && cnt_q != 16'd0) begin
            // The fall before the first DATA rise must not consume the preloaded MSB
            sh_d = sh_q << 1;
          end
        end
        default: ;
      endcase
      if (phase_done) begin
        state_d = spi_slv_next_phase(state_q, |addr_len_q, |dummy_len_q, |data_len_q);
        cnt_d   = '0;
        if (state_d == DATA && is_read_d) rd_req_d = 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_len_q     <= '0;
      addr_len_q    <= '0;
      dummy_len_q   <= '0;
      data_len_q    <= '0;
      rd_cmd_q      <= '0;
      cmd_q         <= '0;
      addr_q        <= '0;
      wr_data_q     <= '0;
      sh_q          <= '0;
      is_read_q     <= 1'b0;
      rd_req_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_len_q     <= cmd_len_d;
      addr_len_q    <= addr_len_d;
      dummy_len_q   <= dummy_len_d;
      data_len_q    <= data_len_d;
      rd_cmd_q      <= rd_cmd_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      wr_data_q     <= wr_data_d;
      sh_q          <= sh_d;
      is_read_q     <= is_read_d;
      rd_req_q      <= rd_req_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign spi_miso    = (state_q == DATA) && is_read_q && sh_q[DATA_W-1];
  assign rd_req      = rd_req_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign cmd         = cmd_q;
  assign addr        = addr_q;
  assign wr_data     = wr_data_q;
  assign is_read     = is_read_q;

endmodule

// File: doc/spi_slave_frame_responder.md
# spi_slave_frame_responder

Synthesizable SPI slave (mode 0, MSB first) that acts as the far end of the PULPino SPI master in the subsystem bench. It deserializes each chip-select frame into CMD, ADDR, DUMMY and DATA phases using per-frame length inputs, and reports captured write frames to the scoreboard side. It also serves read frames by shifting supplied data out on MISO, giving the master's receive path a deterministic responder.

## Interface
- DATA_W, 32, maximum DATA phase bits; also the width of `wr_data` and `rd_data`.
- clk  in  1  system clock; must be at least 8x the SCLK frequency.
- rstn  in  1  reset, asynchronous, active-low.
- spi_sclk  in  1  SPI clock from the master, asynchronous to `clk`.
- spi_cs_n  in  1  chip select, active-low, asynchronous.
- spi_mosi  in  1  master-out data, asynchronous.
- spi_miso  out  1  slave-out data.
- cmd_len  in  6  CMD phase bits; legal range 1..32.
- addr_len  in  6  ADDR phase bits; legal range 0..32.
- dummy_len  in  16  DUMMY phase SCLK cycles; 0 means no DUMMY phase.
- data_len  in  16  DATA phase bits; legal range 0..DATA_W.
- rd_cmd  in  32  command value that selects a read frame.
- rd_req  out  1  one-cycle pulse requesting read data for `addr`.
- rd_data  in  DATA_W  read data; sampled exactly 1 clk after `rd_req`.
- frame_valid  out  1  one-cycle pulse: a complete frame ended.
- frame_err  out  1  one-cycle pulse: illegal length configuration, or CS deasserted mid-frame.
- cmd, addr  out  32 each  captured fields, right-justified, zero-extended.
- wr_data  out  DATA_W  captured MOSI data, right-justified; 0 for read frames.
- is_read  out  1  high if the frame was a read frame.

## Operation
- SCLK, CS_N and MOSI each pass through a 2-flop synchronizer followed by an edge detect.
- Length inputs and `rd_cmd` are latched on the detected CS fall and held for the whole frame.
- States:
  - IDLE: waits for CS fall. If `cmd_len` is 0 or greater than 32, or `addr_len` is greater than 32, or `data_len` is greater than DATA_W, pulse `frame_err` and go to IGNORE. Otherwise go to CMD.
  - CMD: shift MOSI into the command register on each SCLK rise, for `cmd_len` bits.
  - ADDR: same for `addr_len` bits. Skipped when `addr_len` is 0.
  - DUMMY: count `dummy_len` SCLK rises; MOSI is ignored. Skipped when `dummy_len` is 0.
  - DATA: `data_len` bits.
    - Write frame: MOSI is shifted into `wr_data`.
    - Read frame: the MISO shifter outputs its MSB, and shifts on each SCLK fall.
  - DONE: waits for CS rise; SCLK edges are ignored.
  - IGNORE: waits for CS rise with no outputs.
- Read frame detection and data load:
  - `is_read` is decided at the SCLK rise that completes CMD, by comparing `cmd == rd_cmd`.
  - `rd_req` pulses on the SCLK rise that completes the last pre-DATA bit.
  - One clk later, `rd_data[data_len-1:0]` loads the shifter. The first bit appears on MISO before the next SCLK fall.
- Frame end:
  - CS rise in DONE: pulse `frame_valid`, return to IDLE.
  - CS rise in CMD, ADDR, DUMMY or DATA: pulse `frame_err`, no `frame_valid`, return to IDLE.
  - CS rise in IGNORE: return to IDLE with no pulse.
- `data_len` of 0: the frame goes straight to DONE after the last pre-DATA phase, with no `rd_req`.
- Counters are 16 bits and are cleared on every phase entry, so there is no wrap-around.

## Timing
- Reset values: `spi_miso` 0, `rd_req` 0, `frame_valid` 0, `frame_err` 0, `cmd`/`addr`/`wr_data` 0, `is_read` 0. State is IDLE.
- Pin-to-detect latency: 3 clk (2 synchronizer flops plus 1 edge register).
- `frame_valid` pulses 3 clk after the CS rise at the pin. `cmd`, `addr`, `wr_data` and `is_read` are stable from that pulse until the next CS fall is detected.
- `spi_miso` is 0 outside DATA-of-read. A new MISO bit is valid within 4 clk of an SCLK fall.
- If CS rise and an SCLK edge are detected in the same clk, the CS rise wins and the SCLK edge is dropped.
- Asserting reset mid-frame returns to IDLE immediately, with no pulses.

## Structure
- Add to `pulpino_spi_master_subsystem_global_pkg`:
  - `spi_slv_state_e` enum: IDLE, CMD, ADDR, DUMMY, DATA, DONE, IGNORE.
  - Constants `SPI_SLV_MAX_CMD_LEN` = 32 and `SPI_SLV_MAX_ADDR_LEN` = 32.
- One sub-module, `spi_slave_sync_edge`: a 2-flop synchronizer plus rise/fall detect for one bit. It is instantiated three times (SCLK, CS_N, MOSI).

## Test plan
- Write frame: cmd_len=8, addr_len=24, dummy_len=0, data_len=32; master sends cmd 0x02, addr 0x00_1234, data 0xDEAD_BEEF -> `frame_valid` pulses once with cmd=0x02, addr=0x1234, wr_data=0xDEADBEEF, is_read=0.
- Read frame: rd_cmd=0x0B, dummy_len=8, `rd_data`=0xA5A5_0F0F driven the clk after `rd_req` -> one `rd_req` pulse with addr=0x1234; master receives 0xA5A50F0F on MISO; is_read=1; wr_data=0.
- CS abort: CS rises after 5 of the 24 ADDR bits -> `frame_err` pulses, no `frame_valid`; the next legal frame is captured correctly.
- Illegal config: cmd_len=0 or data_len=40 -> `frame_err` pulses at the CS fall; MISO stays 0 and no `frame_valid` occurs.
- Edge cases:
  - addr_len=0, data_len=0: `frame_valid` with only cmd captured and no `rd_req`.
  - 4 extra SCLK cycles after DATA are ignored.
  - Reset asserted mid-DATA: all outputs return to 0 and the state returns to IDLE.
